irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/jm65_irq_pkg.sv | 23 ++
 rtl/irq_sync.sv | 24 ++
 rtl/irq_controller.sv | 154 +++++++++++++++
 tb/tb_irq_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jm65_irq_pkg.sv
// Shared definitions for the interrupt controller: register addresses and data types.
package jm65_irq_pkg;

    typedef logic [7:0] irq_vec_t;

    localparam logic [1:0] IRQ_STATUS = 2'd0;
    localparam logic [1:0] IRQ_MASK   = 2'd1;
    localparam logic [1:0] IRQ_MODE   = 2'd2;
    localparam logic [1:0] IRQ_VECTOR = 2'd3;

    // Channel-enable mask with one bit set for each implemented channel
    function automatic irq_vec_t chan_mask(input int unsigned num_irq);
        irq_vec_t m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < num_irq) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One-bit multi-flop synchronizer for an asynchronous interrupt request line.
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw input through the flop chain; reset flushes it to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: synchronizes requests, latches edge/level pending state,
// applies a mask, and presents a fixed-priority vector plus a registered IRQ line.
module irq_controller
    import jm65_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               we,
    input  logic               re,
    input  logic [1:0]         addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    input  logic               vec_ack,
    output logic               irqb,
    output logic               irq_valid,
    output logic [2:0]         irq_id
);

    localparam irq_vec_t   CH_MASK = chan_mask(NUM_IRQ);
    // Edge detection stays off until the synchronizer has refilled after reset,
    // so a request already high during reset is absorbed into the history flop.
    localparam logic [2:0] WARM    = 3'(SYNC_STAGES + 1);

    irq_vec_t   sync_lvl;
    irq_vec_t   hist_q;
    irq_vec_t   pend_q, pend_d;
    irq_vec_t   mask_q, mask_d;
    irq_vec_t   mode_q, mode_d;
    irq_vec_t   active;
    irq_vec_t   rise;
    irq_vec_t   w1c;
    irq_vec_t   ack_clr;
    irq_vec_t   mode_chg;
    irq_vec_t   read_val;
    logic [2:0] warm_q;
    logic [7:0] rdata_q;
    logic       irqb_q;

    // One synchronizer per implemented channel; unused channels read as zero
    for (genvar g = 0; g < 8; g++) begin : g_sync
        if (g < NUM_IRQ) begin : g_used
            irq_sync #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (irq_src[g]),
                .q     (sync_lvl[g])
            );
        end else begin : g_unused
            assign sync_lvl[g] = 1'b0;
        end
    end

    // Fixed-priority encoder: lowest enabled pending index wins
    always_comb begin
        active    = pend_q & mask_q;
        irq_valid = |active;
        irq_id    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                irq_id = 3'(i);
            end
        end
    end

    // Register write decode and clear sources
    always_comb begin
        w1c    = '0;
        mask_d = mask_q;
        mode_d = mode_q;
        if (we) begin
            unique case (addr)
                IRQ_STATUS: w1c    = wdata & CH_MASK;
                IRQ_MASK:   mask_d = wdata & CH_MASK;
                IRQ_MODE:   mode_d = wdata & CH_MASK;
                default:    ;
            endcase
        end
        mode_chg = mode_d ^ mode_q;
        ack_clr  = '0;
        if (vec_ack && irq_valid) begin
            ack_clr[irq_id] = 1'b1;
        end
        rise = (warm_q == 3'd0) ? (sync_lvl & ~hist_q) : '0;
    end

    // Pending next state: a new edge beats W1C/ack, a mode change beats everything
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = pend_q[i];
                if (w1c[i] || ack_clr[i]) begin
                    pend_d[i] = 1'b0;
                end
                if (rise[i]) begin
                    pend_d[i] = 1'b1;
                end
            end else begin
                pend_d[i] = sync_lvl[i];
            end
            if (mode_chg[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        pend_d = pend_d & CH_MASK;
    end

    // Read mux; uses pre-write register values so a same-cycle write is not visible
    always_comb begin
        read_val = '0;
        unique case (addr)
            IRQ_STATUS: read_val = pend_q;
            IRQ_MASK:   read_val = mask_q;
            IRQ_MODE:   read_val = mode_q;
            IRQ_VECTOR: read_val = {irq_valid, 4'b0000, irq_id};
            default:    read_val = '0;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= CH_MASK;
            hist_q  <= '0;
            warm_q  <= WARM;
            rdata_q <= '0;
            irqb_q  <= 1'b1;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            hist_q <= sync_lvl;
            if (warm_q != 3'd0) begin
                warm_q <= warm_q - 3'd1;
            end
            if (re) begin
                rdata_q <= read_val;
            end
            irqb_q <= ~irq_valid;
        end
    end

    assign rdata = rdata_q;
    assign irqb  = irqb_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table plus interrupt scenarios.
module tb_irq_controller;

    localparam int unsigned NUM_IRQ = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_src;
    logic               we, re, vec_ack;
    logic [1:0]         addr;
    logic [7:0]         wdata;
    logic [7:0]         rdata;
    logic               irqb, irq_valid;
    logic [2:0]         irq_id;

    irq_controller #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .we        (we),
        .re        (re),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .vec_ack   (vec_ack),
        .irqb      (irqb),
        .irq_valid (irq_valid),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[10];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Read: expected value queued at issue, popped and compared once rdata is loaded
    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
        sb_t e;
        re = 1'b1; addr = a;
        sbq.push_back('{exp: exp, name: name});
        tick();
        re = 1'b0;
        e = sbq.pop_front();
        chk(e.name, rdata, e.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{wr: 1'b0, addr: 2'd0, wdata: 8'h00, exp: 8'h00, name: "rst_status"};
        tbl[1] = '{wr: 1'b0, addr: 2'd1, wdata: 8'h00, exp: 8'h00, name: "rst_mask"};
        tbl[2] = '{wr: 1'b0, addr: 2'd2, wdata: 8'h00, exp: 8'hFF, name: "rst_mode"};
        tbl[3] = '{wr: 1'b0, addr: 2'd3, wdata: 8'h00, exp: 8'h00, name: "rst_vector"};
        tbl[4] = '{wr: 1'b1, addr: 2'd1, wdata: 8'hA5, exp: 8'hA5, name: "mask_rw"};
        tbl[5] = '{wr: 1'b1, addr: 2'd2, wdata: 8'h3C, exp: 8'h3C, name: "mode_rw"};
        tbl[6] = '{wr: 1'b1, addr: 2'd3, wdata: 8'h55, exp: 8'h00, name: "vector_wr_ignored"};
        tbl[7] = '{wr: 1'b1, addr: 2'd0, wdata: 8'hFF, exp: 8'h00, name: "status_w1c_idle"};
        tbl[8] = '{wr: 1'b1, addr: 2'd2, wdata: 8'hFF, exp: 8'hFF, name: "mode_restore"};
        tbl[9] = '{wr: 1'b1, addr: 2'd1, wdata: 8'h00, exp: 8'h00, name: "mask_restore"};

        reset = 1'b1; irq_src = '0; we = 1'b0; re = 1'b0; vec_ack = 1'b0;
        addr = 2'd0; wdata = 8'h00;
        repeat (3) tick();
        chk("rst_irqb", {7'd0, irqb}, 8'h01);
        chk("rst_rdata", rdata, 8'h00);
        reset = 1'b0;
        repeat (6) tick();

        // Register table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
        end
        tick();
        chk("rdata_hold", rdata, 8'h00);

        // Same-cycle write and read of MASK returns the old value
        we = 1'b1; re = 1'b1; addr = 2'd1; wdata = 8'h5A;
        sbq.push_back('{exp: 8'h00, name: "rw_same_cycle"});
        tick();
        we = 1'b0; re = 1'b0;
        begin
            sb_t e;
            e = sbq.pop_front();
            chk(e.name, rdata, e.exp);
        end
        rd(2'd1, 8'h5A, "rw_after_write");
        wr(2'd1, 8'h00);

        // Latency: one-cycle pulse on ch0 drives irqb low exactly four edges later
        wr(2'd1, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        tick();
        tick();
        chk("lat_irqb_edge3", {7'd0, irqb}, 8'h01);
        tick();
        chk("lat_irqb_edge4", {7'd0, irqb}, 8'h00);
        rd(2'd3, 8'h80, "lat_vector");
        vec_ack = 1'b1;
        tick();
        vec_ack = 1'b0;
        tick();
        chk("lat_ack_irqb", {7'd0, irqb}, 8'h01);

        // Priority: ch2 beats ch5, acks walk down the list
        wr(2'd1, 8'hFF);
        irq_src[5] = 1'b1; irq_src[2] = 1'b1;
        repeat (3) tick();
        chk("prio_id_2", {5'd0, irq_id}, 8'h02);
        chk("prio_valid", {7'd0, irq_valid}, 8'h01);
        rd(2'd3, 8'h82, "prio_vector");
        vec_ack = 1'b1;
        tick();
        vec_ack = 1'b0;
        chk("prio_id_5", {5'd0, irq_id}, 8'h05);
        vec_ack = 1'b1;
        tick();
        vec_ack = 1'b0;
        tick();
        chk("prio_irqb_clear", {7'd0, irqb}, 8'h01);
        rd(2'd0, 8'h00, "prio_status_clear");
        irq_src = '0;
        repeat (3) tick();

        // Level mode on ch0: W1C has no effect, drop clears after three edges
        wr(2'd2, 8'hFE);
        irq_src[0] = 1'b1;
        repeat (3) tick();
        rd(2'd0, 8'h01, "level_set");
        wr(2'd0, 8'h01);
        rd(2'd0, 8'h01, "level_w1c_ignored");
        irq_src[0] = 1'b0;
        tick();
        tick();
        rd(2'd0, 8'h01, "level_still_set_edge2");
        rd(2'd0, 8'h00, "level_clear_edge3");
        wr(2'd2, 8'hFF);

        // Edge on ch3 lands in the same cycle as W1C of bit 3: edge wins
        irq_src[3] = 1'b1;
        tick();
        tick();
        wr(2'd0, 8'h08);
        rd(2'd0, 8'h08, "edge_beats_w1c");
        wr(2'd0, 8'h08);
        rd(2'd0, 8'h00, "w1c_clears");
        irq_src[3] = 1'b0;
        repeat (3) tick();

        // Masked pending ch1, then unmask
        wr(2'd1, 8'h00);
        irq_src[1] = 1'b1;
        repeat (4) tick();
        chk("masked_irqb", {7'd0, irqb}, 8'h01);
        rd(2'd0, 8'h02, "masked_status");
        wr(2'd1, 8'h02);
        chk("unmask_irqb_edge1", {7'd0, irqb}, 8'h01);
        tick();
        chk("unmask_irqb_edge2", {7'd0, irqb}, 8'h00);
        vec_ack = 1'b1;
        tick();
        vec_ack = 1'b0;
        irq_src[1] = 1'b0;
        repeat (3) tick();

        // Reset mid-operation with ch4 pending and held high
        wr(2'd1, 8'h10);
        irq_src[4] = 1'b1;
        repeat (4) tick();
        chk("pre_reset_irqb", {7'd0, irqb}, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset_irqb", {7'd0, irqb}, 8'h01);
        rd(2'd0, 8'h00, "mid_reset_status");
        rd(2'd1, 8'h00, "mid_reset_mask");
        rd(2'd2, 8'hFF, "mid_reset_mode");
        wr(2'd1, 8'h10);
        repeat (8) tick();
        rd(2'd0, 8'h00, "post_reset_no_pending");
        chk("post_reset_irqb", {7'd0, irqb}, 8'h01);
        irq_src[4] = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
